// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------------------------
// control_unit
//   Multi-cycle control sequencer for the ezRISC bus datapath. It fetches an instruction into
//   IR, decodes it, and steps the datapath through ADD/SUB/AND/OR/MUL/ADDI/LD/ST/HALT by driving
//   register load enables, bus-drive selects, the ALU op and the memory strobes. Its only
//   feedback from the datapath is the IR contents and the memory ready flag.
//
// Ports
//   i_clk          system clock, all state on the rising edge
//   i_reset        synchronous active-high reset; forces every output to 0 while high
//   i_run          1 allows a new fetch to start in T0
//   i_mem_ready    memory completed the current read/write this cycle
//   i_ir           IR contents: op=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15]
//   o_gpr_in       one-hot load enable, R0..R15
//   o_gpr_out      one-hot bus-drive select, R0..R15
//   o_*_in         load enables for PC, IR, Y, Z, MAR, MDR, HI, LO
//   o_*_out        bus-drive selects for PC, MDR, Z high/low, HI, LO, C (sign-extended ir[18:0])
//   o_read/o_write memory strobes, held through the wait on i_mem_ready
//   o_alu_op       0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 MUL, 1111 INC4
//   o_halted       high while in the halted state
//   o_illegal      one-cycle pulse in T3 on an undefined opcode
// ---------------------------------------------------------------------------------------------
module control_unit #(
    parameter int unsigned REG_SIZE = 32,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_mem_ready,
    input  logic [REG_SIZE-1:0] i_ir,
    output logic [15:0]         o_gpr_in,
    output logic [15:0]         o_gpr_out,
    output logic                o_pc_in,
    output logic                o_ir_in,
    output logic                o_y_in,
    output logic                o_z_in,
    output logic                o_mar_in,
    output logic                o_mdr_in,
    output logic                o_hi_in,
    output logic                o_lo_in,
    output logic                o_pc_out,
    output logic                o_mdr_out,
    output logic                o_z_high_out,
    output logic                o_z_low_out,
    output logic                o_hi_out,
    output logic                o_lo_out,
    output logic                o_c_out,
    output logic                o_read,
    output logic                o_write,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_halted,
    output logic                o_illegal
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_LD   = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = ALU_OP_W'(4'b0100);
    localparam logic [ALU_OP_W-1:0] ALU_INC4 = ALU_OP_W'(4'b1111);

    typedef enum logic [3:0] {
        StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalted
    } state_e;

    state_e r_state;

    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [15:0] w_ra_sel;
    logic [15:0] w_rb_sel;
    logic [15:0] w_rc_sel;
    logic        w_is_rtype;
    logic        w_is_addi;
    logic        w_is_mul;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_halt;
    logic        w_is_legal;
    logic        w_unused_ir;

    assign w_op     = i_ir[31:27];
    assign w_ra     = i_ir[26:23];
    assign w_rb     = i_ir[22:19];
    assign w_rc     = i_ir[18:15];
    assign w_ra_sel = 16'h0001 << w_ra;
    assign w_rb_sel = 16'h0001 << w_rb;
    assign w_rc_sel = 16'h0001 << w_rc;

    // Low immediate bits only matter to the datapath's sign extender.
    assign w_unused_ir = ^i_ir[14:0];

    // ADD/SUB/AND/OR share op[4:2]=000 and their op[1:0] is the ALU code.
    assign w_is_rtype = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                        (w_op == OP_AND) || (w_op == OP_OR);
    assign w_is_addi  = (w_op == OP_ADDI);
    assign w_is_mul   = (w_op == OP_MUL);
    assign w_is_ld    = (w_op == OP_LD);
    assign w_is_st    = (w_op == OP_ST);
    assign w_is_halt  = (w_op == OP_HALT);
    assign w_is_legal = w_is_rtype | w_is_addi | w_is_mul | w_is_ld | w_is_st | w_is_halt;

    // Sequencer state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StT0;
        end else begin
            unique case (r_state)
                StT0: if (i_run) r_state <= StT1;
                StT1: if (i_mem_ready) r_state <= StT2;
                StT2: r_state <= StT3;
                StT3: begin
                    if (w_is_halt)       r_state <= StHalted;
                    else if (w_is_legal) r_state <= StT4;
                    else                 r_state <= StT0;
                end
                StT4: r_state <= StT5;
                StT5: begin
                    if (w_is_rtype || w_is_addi) r_state <= StT0;
                    else                         r_state <= StT6;
                end
                StT6: begin
                    if (w_is_ld) begin
                        if (i_mem_ready) r_state <= StT7;
                    end else if (w_is_st) begin
                        r_state <= StT7;
                    end else begin
                        r_state <= StT0;
                    end
                end
                StT7: begin
                    // LD finishes unconditionally; ST waits for the write to complete.
                    if (w_is_ld || i_mem_ready) r_state <= StT0;
                end
                StHalted: r_state <= StHalted;
                default:  r_state <= StT0;
            endcase
        end
    end

    // Output decode. Gated by reset so an in-flight memory strobe drops in the reset cycle.
    always_comb begin
        o_gpr_in     = '0;
        o_gpr_out    = '0;
        o_pc_in      = 1'b0;
        o_ir_in      = 1'b0;
        o_y_in       = 1'b0;
        o_z_in       = 1'b0;
        o_mar_in     = 1'b0;
        o_mdr_in     = 1'b0;
        o_hi_in      = 1'b0;
        o_lo_in      = 1'b0;
        o_pc_out     = 1'b0;
        o_mdr_out    = 1'b0;
        o_z_high_out = 1'b0;
        o_z_low_out  = 1'b0;
        o_hi_out     = 1'b0;
        o_lo_out     = 1'b0;
        o_c_out      = 1'b0;
        o_read       = 1'b0;
        o_write      = 1'b0;
        o_alu_op     = ALU_ADD;
        o_halted     = 1'b0;
        o_illegal    = 1'b0;
        if (!i_reset) begin
            unique case (r_state)
                StT0: begin
                    if (i_run) begin
                        o_pc_out = 1'b1;
                        o_mar_in = 1'b1;
                        o_z_in   = 1'b1;
                        o_alu_op = ALU_INC4;
                    end
                end
                StT1: begin
                    // PC reloads from Z every wait cycle; Z is stable so this is harmless.
                    o_z_low_out = 1'b1;
                    o_pc_in     = 1'b1;
                    o_read      = 1'b1;
                    o_mdr_in    = 1'b1;
                end
                StT2: begin
                    o_mdr_out = 1'b1;
                    o_ir_in   = 1'b1;
                end
                StT3: begin
                    if (!w_is_legal) begin
                        o_illegal = 1'b1;
                    end else if (!w_is_halt) begin
                        o_gpr_out = w_rb_sel;
                        o_y_in    = 1'b1;
                    end
                end
                StT4: begin
                    o_z_in = 1'b1;
                    if (w_is_rtype || w_is_mul) o_gpr_out = w_rc_sel;
                    else                        o_c_out   = 1'b1;
                    if (w_is_rtype)    o_alu_op = ALU_OP_W'(w_op[1:0]);
                    else if (w_is_mul) o_alu_op = ALU_MUL;
                end
                StT5: begin
                    o_z_low_out = 1'b1;
                    if (w_is_rtype || w_is_addi) o_gpr_in = w_ra_sel;
                    else if (w_is_mul)           o_lo_in  = 1'b1;
                    else                         o_mar_in = 1'b1;
                end
                StT6: begin
                    if (w_is_mul) begin
                        o_z_high_out = 1'b1;
                        o_hi_in      = 1'b1;
                    end else if (w_is_ld) begin
                        o_read   = 1'b1;
                        o_mdr_in = 1'b1;
                    end else if (w_is_st) begin
                        // read is low, so MDR takes the bus rather than memory.
                        o_gpr_out = w_ra_sel;
                        o_mdr_in  = 1'b1;
                    end
                end
                StT7: begin
                    if (w_is_ld) begin
                        o_mdr_out = 1'b1;
                        o_gpr_in  = w_ra_sel;
                    end else if (w_is_st) begin
                        o_write = 1'b1;
                    end
                end
                StHalted: o_halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a table of per-cycle {inputs, expected outputs} records is built up
// front, then driven one record per cycle; expected words go through a scoreboard queue and are
// compared against the DUT on the falling edge.
module tb_control_unit;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_LD   = 5'b00100;
    localparam logic [4:0] OP_ST   = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // Output word layout: {gpr_in[15:0], gpr_out[15:0], 17 single bits, alu_op[3:0], halted, illegal}
    localparam logic [54:0] PC_IN      = 55'd1 << 22;
    localparam logic [54:0] IR_IN      = 55'd1 << 21;
    localparam logic [54:0] Y_IN       = 55'd1 << 20;
    localparam logic [54:0] Z_IN       = 55'd1 << 19;
    localparam logic [54:0] MAR_IN     = 55'd1 << 18;
    localparam logic [54:0] MDR_IN     = 55'd1 << 17;
    localparam logic [54:0] HI_IN      = 55'd1 << 16;
    localparam logic [54:0] LO_IN      = 55'd1 << 15;
    localparam logic [54:0] PC_OUT     = 55'd1 << 14;
    localparam logic [54:0] MDR_OUT    = 55'd1 << 13;
    localparam logic [54:0] Z_HIGH_OUT = 55'd1 << 12;
    localparam logic [54:0] Z_LOW_OUT  = 55'd1 << 11;
    localparam logic [54:0] C_OUT      = 55'd1 << 8;
    localparam logic [54:0] READ       = 55'd1 << 7;
    localparam logic [54:0] WRITE      = 55'd1 << 6;
    localparam logic [54:0] HALTED     = 55'd1 << 1;
    localparam logic [54:0] ILLEGAL    = 55'd1 << 0;
    localparam logic [54:0] INC4       = 55'd15 << 2;
    localparam logic [54:0] T0_RUN     = PC_OUT | MAR_IN | Z_IN | INC4;
    localparam logic [54:0] FETCH1     = Z_LOW_OUT | PC_IN | READ | MDR_IN;
    localparam logic [54:0] FETCH2     = MDR_OUT | IR_IN;

    typedef struct {
        logic        rst;
        logic        run;
        logic        rdy;
        logic [31:0] ir;
        logic [54:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [15:0] gpr_in, gpr_out;
    logic        pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in;
    logic        pc_out, mdr_out, z_high_out, z_low_out, hi_out, lo_out, c_out;
    logic        rd, wr, halted, illegal;
    logic [3:0]  alu_op;

    vec_t        vecs[$];
    logic [54:0] sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    control_unit #(.REG_SIZE(32), .ALU_OP_W(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_run(run), .i_mem_ready(mem_ready), .i_ir(ir),
        .o_gpr_in(gpr_in), .o_gpr_out(gpr_out),
        .o_pc_in(pc_in), .o_ir_in(ir_in), .o_y_in(y_in), .o_z_in(z_in),
        .o_mar_in(mar_in), .o_mdr_in(mdr_in), .o_hi_in(hi_in), .o_lo_in(lo_in),
        .o_pc_out(pc_out), .o_mdr_out(mdr_out), .o_z_high_out(z_high_out),
        .o_z_low_out(z_low_out), .o_hi_out(hi_out), .o_lo_out(lo_out), .o_c_out(c_out),
        .o_read(rd), .o_write(wr), .o_alu_op(alu_op), .o_halted(halted), .o_illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [54:0] gi(input int n);
        logic [54:0] r;
        r = '0;
        r[39 + n] = 1'b1;
        return r;
    endfunction

    function automatic logic [54:0] go(input int n);
        logic [54:0] r;
        r = '0;
        r[23 + n] = 1'b1;
        return r;
    endfunction

    function automatic logic [54:0] alu(input logic [3:0] a);
        return 55'(a) << 2;
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] low);
        return {op, ra, rb, low};
    endfunction

    task automatic add(input logic rst, input logic rn, input logic rdy,
                       input logic [31:0] i, input logic [54:0] e);
        vec_t v;
        v.rst = rst; v.run = rn; v.rdy = rdy; v.ir = i; v.exp = e;
        vecs.push_back(v);
    endtask

    // T0..T2; run toggles during T1/T2 to show it is only looked at in T0.
    task automatic fetch(input logic [31:0] i, input int waits);
        add(1'b0, 1'b1, 1'b0, i, T0_RUN);
        for (int k = 0; k < waits; k++) add(1'b0, k[0], 1'b0, i, FETCH1);
        add(1'b0, 1'b0, 1'b1, i, FETCH1);
        add(1'b0, 1'b1, 1'b0, i, FETCH2);
    endtask

    // R-type or ADDI; mem_ready is toggled in T3..T5 where it must be ignored.
    task automatic alu_instr(input logic [4:0] op, input int ra, input int rb, input int rc,
                             input logic [3:0] a, input int waits);
        logic [31:0] i;
        logic        imm;
        imm = (op == OP_ADDI);
        i = imm ? enc(op, 4'(ra), 4'(rb), 19'h7ffc3) : enc(op, 4'(ra), 4'(rb), {4'(rc), 15'h0});
        fetch(i, waits);
        add(1'b0, 1'b0, 1'b1, i, go(rb) | Y_IN);
        add(1'b0, 1'b1, 1'b0, i, (imm ? C_OUT : go(rc)) | Z_IN | alu(a));
        add(1'b0, 1'b0, 1'b1, i, gi(ra) | Z_LOW_OUT);
    endtask

    // LD/ST address phase T3..T5.
    task automatic mem_addr(input logic [31:0] i, input int rb);
        add(1'b0, 1'b0, 1'b1, i, go(rb) | Y_IN);
        add(1'b0, 1'b0, 1'b1, i, C_OUT | Z_IN | alu(4'b0000));
        add(1'b0, 1'b0, 1'b1, i, Z_LOW_OUT | MAR_IN);
    endtask

    // Per-cycle compare plus the single-bus-driver invariant.
    always @(negedge clk) begin
        logic [54:0] got, e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = {gpr_in, gpr_out, pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in,
                   pc_out, mdr_out, z_high_out, z_low_out, hi_out, lo_out, c_out, rd, wr,
                   alu_op, halted, illegal};
            n_vec++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL vec%0d outputs: got %h want %h (diff %h)", n_vec - 1, got, e,
                         got ^ e);
            end
            if ($countones({gpr_out, pc_out, mdr_out, z_high_out, z_low_out, hi_out, lo_out,
                            c_out}) > 1) begin
                n_fail++;
                $display("FAIL vec%0d bus_onehot: got %0d drivers want <=1", n_vec - 1,
                         $countones({gpr_out, pc_out, mdr_out, z_high_out, z_low_out, hi_out,
                                     lo_out, c_out}));
            end
        end
    end

    initial begin
        logic [31:0] i;
        reset = 1'b1; run = 1'b1; mem_ready = 1'b1; ir = '0;

        // Reset with run high, then the first fetch starts immediately.
        add(1'b1, 1'b1, 1'b1, 32'h0, '0);
        add(1'b1, 1'b1, 1'b1, 32'h0, '0);
        alu_instr(OP_ADD, 3, 1, 2, 4'b0000, 0);
        add(1'b0, 1'b0, 1'b1, 32'h0, '0);
        add(1'b0, 1'b0, 1'b0, 32'h0, '0);
        alu_instr(OP_SUB, 1, 2, 3, 4'b0001, 2);
        alu_instr(OP_AND, 15, 0, 14, 4'b0010, 0);
        alu_instr(OP_OR, 0, 7, 8, 4'b0011, 1);
        alu_instr(OP_ADDI, 9, 10, 0, 4'b0000, 0);

        // LD R5,0x10(R2) with three wait states in T6.
        i = enc(OP_LD, 4'd5, 4'd2, 19'h00010);
        fetch(i, 0);
        mem_addr(i, 2);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b0, i, READ | MDR_IN);
        add(1'b0, 1'b0, 1'b1, i, READ | MDR_IN);
        add(1'b0, 1'b0, 1'b0, i, MDR_OUT | gi(5));

        // MUL R0,R4,R6; mem_ready low in T6 must not stall it.
        i = enc(OP_MUL, 4'd0, 4'd4, {4'd6, 15'h0});
        fetch(i, 0);
        add(1'b0, 1'b0, 1'b0, i, go(4) | Y_IN);
        add(1'b0, 1'b0, 1'b0, i, go(6) | Z_IN | alu(4'b0100));
        add(1'b0, 1'b0, 1'b0, i, Z_LOW_OUT | LO_IN);
        add(1'b0, 1'b0, 1'b0, i, Z_HIGH_OUT | HI_IN);

        // ST R7,0x8(R1) with one write wait state.
        i = enc(OP_ST, 4'd7, 4'd1, 19'h00008);
        fetch(i, 0);
        mem_addr(i, 1);
        add(1'b0, 1'b0, 1'b1, i, go(7) | MDR_IN);
        add(1'b0, 1'b0, 1'b0, i, WRITE);
        add(1'b0, 1'b0, 1'b1, i, WRITE);

        // Undefined opcodes pulse illegal once, then back to T0.
        i = enc(5'b10101, 4'd1, 4'd2, 19'h0);
        fetch(i, 0);
        add(1'b0, 1'b0, 1'b1, i, ILLEGAL);
        add(1'b0, 1'b0, 1'b1, i, '0);
        i = enc(5'b00110, 4'd1, 4'd2, 19'h0);
        fetch(i, 0);
        add(1'b0, 1'b1, 1'b1, i, ILLEGAL);

        // Reset during the ST write wait abandons the access.
        i = enc(OP_ST, 4'd2, 4'd3, 19'h00004);
        fetch(i, 0);
        mem_addr(i, 3);
        add(1'b0, 1'b0, 1'b0, i, go(2) | MDR_IN);
        add(1'b0, 1'b0, 1'b0, i, WRITE);
        add(1'b1, 1'b0, 1'b0, i, '0);
        add(1'b0, 1'b0, 1'b0, i, '0);

        // HALT: only reset leaves the halted state.
        i = enc(OP_HALT, 4'd0, 4'd0, 19'h0);
        fetch(i, 0);
        add(1'b0, 1'b1, 1'b1, i, '0);
        for (int k = 0; k < 100; k++) add(1'b0, k[0], k[1], i, HALTED);
        add(1'b1, 1'b1, 1'b1, i, '0);
        add(1'b0, 1'b1, 1'b1, i, T0_RUN);

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            reset     = vecs[k].rst;
            run       = vecs[k].run;
            mem_ready = vecs[k].rdy;
            ir        = vecs[k].ir;
            sb.push_back(vecs[k].exp);
        end
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
